drive_cmd_arbiter: RTL and testbench

- Owns the single UART command byte path to the simulated car, replacing the direct `{2'b10, destroy, place, right, left, back, fwd}` assembly.
- Arbitrates three command sources by selected mode: manual (0), semi-auto (1), auto (2).
- Sanitizes conflicting bits, converts barrier requests to one-frame pulses, and inserts a stop dead-time on every ownership change.
- Paces frames to the UART with a valid/ready handshake and periodic refresh.

---
 rtl/drive_cmd_pkg.sv | 25 ++
 rtl/drive_cmd_sanitize.sv | 67 ++++++
 rtl/drive_cmd_arbiter.sv | 146 ++++++++++++++
 tb/tb_drive_cmd_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/drive_cmd_pkg.sv
// Shared encodings for the drive command path: source ids, frame layout and arbiter states.
package drive_cmd_pkg;

    localparam logic [1:0] SRC_MAN  = 2'd0;
    localparam logic [1:0] SRC_SEMI = 2'd1;
    localparam logic [1:0] SRC_AUTO = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    localparam logic [1:0] FRAME_HDR  = 2'b10;
    localparam logic [7:0] STOP_FRAME = 8'h80;

    localparam int FWD     = 0;
    localparam int BACK    = 1;
    localparam int LEFT    = 2;
    localparam int RIGHT   = 3;
    localparam int PLACE   = 4;
    localparam int DESTROY = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OWNED    = 2'd1,
        ST_DEADTIME = 2'd2
    } state_e;

endpackage

// File: rtl/drive_cmd_sanitize.sv
// Registered conflict clearing of opposing command bits plus sticky one-frame barrier latches.
module drive_cmd_sanitize
    import drive_cmd_pkg::*;
(
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [5:0] cmd_i,
    input  logic       flush_i,
    input  logic       clr_place_i,
    input  logic       clr_destroy_i,
    output logic [5:0] cmd_o,
    output logic       conflict_o
);

    logic [2:0] pair_hit;
    logic [2:0] pair_q;
    logic [5:0] clean;
    logic [3:0] mv_q;
    logic [1:0] bar_prev_q;
    logic [1:0] bar_lat_q, bar_lat_d;
    logic [1:0] bar_rise;
    logic       conflict_q;

    always_comb begin
        pair_hit = {cmd_i[PLACE] & cmd_i[DESTROY], cmd_i[LEFT] & cmd_i[RIGHT], cmd_i[FWD] & cmd_i[BACK]};
        clean = cmd_i;
        if (pair_hit[0]) begin
            clean[FWD]  = 1'b0;
            clean[BACK] = 1'b0;
        end
        if (pair_hit[1]) begin
            clean[LEFT]  = 1'b0;
            clean[RIGHT] = 1'b0;
        end
        if (pair_hit[2]) begin
            clean[PLACE]   = 1'b0;
            clean[DESTROY] = 1'b0;
        end
        // A fresh edge wins over an accept clear so a new request is never lost.
        bar_rise  = {clean[DESTROY], clean[PLACE]} & ~bar_prev_q;
        bar_lat_d = bar_lat_q;
        if (clr_place_i)   bar_lat_d[0] = 1'b0;
        if (clr_destroy_i) bar_lat_d[1] = 1'b0;
        bar_lat_d = bar_lat_d | bar_rise;
        if (flush_i)       bar_lat_d = '0;
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            pair_q     <= '0;
            mv_q       <= '0;
            bar_prev_q <= '0;
            bar_lat_q  <= '0;
            conflict_q <= 1'b0;
        end else begin
            pair_q     <= pair_hit;
            mv_q       <= clean[3:0];
            bar_prev_q <= {clean[DESTROY], clean[PLACE]};
            bar_lat_q  <= bar_lat_d;
            conflict_q <= |(pair_hit & ~pair_q);
        end
    end

    assign cmd_o      = {bar_lat_q[1], bar_lat_q[0], mv_q};
    assign conflict_o = conflict_q;

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Owns the UART drive byte: picks the command owner, enforces stop dead-time and paces frames.
module drive_cmd_arbiter
    import drive_cmd_pkg::*;
#(
    parameter int REFRESH_CYCLES  = 100000,
    parameter int DEADTIME_CYCLES = 2000000,
    parameter int CNT_W           = 24
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [1:0] mode_sel,
    input  logic [2:0] req,
    input  logic [5:0] cmd_man,
    input  logic [5:0] cmd_semi,
    input  logic [5:0] cmd_auto,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic [2:0] grant,
    output logic       conflict,
    output logic       in_deadtime
);

    localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'(DEADTIME_CYCLES - 1);
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] REFRESH_DUE  = CNT_W'(REFRESH_CYCLES - 2);

    state_e           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] dead_q, dead_d;
    logic [CNT_W-1:0] refresh_q, refresh_d;
    logic [7:0]       last_q, last_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [5:0]       eff_cmd, san_cmd;
    logic [7:0]       cur_byte;
    logic             accept, refresh_due;

    assign accept      = tx_valid_q & tx_ready;
    assign refresh_due = refresh_q >= REFRESH_DUE;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        dead_d  = dead_q;
        case (state_q)
            ST_IDLE: begin
                if (mode_sel != SRC_NONE) begin
                    state_d = ST_DEADTIME;
                    owner_d = mode_sel;
                    dead_d  = '0;
                end
            end
            ST_OWNED: begin
                if (mode_sel != owner_q) begin
                    state_d = ST_DEADTIME;
                    owner_d = mode_sel;
                    dead_d  = '0;
                end
            end
            ST_DEADTIME: begin
                if (mode_sel != owner_q) begin
                    owner_d = mode_sel;
                    dead_d  = '0;
                end else if (dead_q == DEAD_LAST) begin
                    state_d = (owner_q == SRC_NONE) ? ST_IDLE : ST_OWNED;
                    dead_d  = '0;
                end else begin
                    dead_d = dead_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        eff_cmd = '0;
        grant   = '0;
        if (state_q == ST_OWNED) begin
            case (owner_q)
                SRC_MAN:  begin grant = 3'b001; if (req[0]) eff_cmd = cmd_man;  end
                SRC_SEMI: begin grant = 3'b010; if (req[1]) eff_cmd = cmd_semi; end
                SRC_AUTO: begin grant = 3'b100; if (req[2]) eff_cmd = cmd_auto; end
                default:  begin grant = 3'b000; eff_cmd = '0; end
            endcase
        end
    end

    drive_cmd_sanitize u_sanitize (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .cmd_i        (eff_cmd),
        .flush_i      (state_d != ST_OWNED),
        .clr_place_i  (accept & tx_data_q[PLACE]),
        .clr_destroy_i(accept & tx_data_q[DESTROY]),
        .cmd_o        (san_cmd),
        .conflict_o   (conflict)
    );

    assign cur_byte = (state_q == ST_OWNED) ? {FRAME_HDR, san_cmd} : STOP_FRAME;

    // On accept the next frame is judged against the byte leaving now, not the stale last_sent.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        last_d     = last_q;
        refresh_d  = refresh_q;
        if (accept) begin
            last_d     = tx_data_q;
            refresh_d  = '0;
            tx_valid_d = (cur_byte != tx_data_q);
            tx_data_d  = cur_byte;
        end else begin
            if (refresh_q != REFRESH_LAST) refresh_d = refresh_q + CNT_W'(1);
            if (!tx_valid_q) begin
                tx_valid_d = (cur_byte != last_q) || refresh_due;
                tx_data_d  = cur_byte;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= SRC_NONE;
            dead_q     <= '0;
            refresh_q  <= '0;
            last_q     <= '0;
            tx_data_q  <= STOP_FRAME;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            dead_q     <= dead_d;
            refresh_q  <= refresh_d;
            last_q     <= last_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign in_deadtime = (state_q == ST_DEADTIME);

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Bench for drive_cmd_arbiter with short refresh and dead-time counts.
module tb_drive_cmd_arbiter;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] mode_sel;
    logic [2:0] req;
    logic [5:0] cmd_man, cmd_semi, cmd_auto;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [2:0] grant;
    logic       conflict;
    logic       in_deadtime;

    always #5 sys_clk = ~sys_clk;

    drive_cmd_arbiter #(.REFRESH_CYCLES(16), .DEADTIME_CYCLES(8), .CNT_W(24)) dut (
        .sys_clk(sys_clk), .rst(rst), .mode_sel(mode_sel), .req(req),
        .cmd_man(cmd_man), .cmd_semi(cmd_semi), .cmd_auto(cmd_auto),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .grant(grant), .conflict(conflict), .in_deadtime(in_deadtime)
    );

    typedef struct {
        logic [1:0] mode;
        logic [2:0] rq;
        logic [5:0] man;
        logic [5:0] semi;
        logic [5:0] aut;
        logic [7:0] frame;
        logic [2:0] gnt;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         acc_t[$];
    logic [7:0] last_frame = 8'h00;
    vec_t       vecs[9];

    // Accepted frames are captured on the falling edge ahead of the accepting rising edge.
    always @(negedge sys_clk) begin
        cyc++;
        if (rst && tx_valid && tx_ready) begin
            got_q.push_back(tx_data);
            acc_t.push_back(cyc);
            last_frame = tx_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_valid(input int max);
        int i;
        i = 0;
        while (!tx_valid && i < max) begin
            step(1);
            i++;
        end
        chk("wait_valid", int'(tx_valid), 1);
    endtask

    // Collapses refresh repeats, then pops the expected frame sequence against what was accepted.
    task automatic check_frames(input string nm, input logic [7:0] prev);
        logic [7:0] comp[$];
        logic [7:0] lastv;
        logic [7:0] e;
        int         n;
        lastv = prev;
        foreach (got_q[i]) begin
            if (got_q[i] != lastv) begin
                comp.push_back(got_q[i]);
                lastv = got_q[i];
            end
        end
        n = exp_q.size();
        chk({nm, "_nframes"}, comp.size(), n);
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            chk(nm, (i < comp.size()) ? int'(comp[i]) : -1, int'(e));
        end
        got_q.delete();
    endtask

    initial begin
        int n;
        int bad;
        int n90;
        int n85;
        vecs[0] = '{2'd0, 3'b001, 6'b000110, 6'd0, 6'd0, 8'h86, 3'b001};
        vecs[1] = '{2'd0, 3'b000, 6'b000110, 6'd0, 6'd0, 8'h80, 3'b001};
        vecs[2] = '{2'd1, 3'b010, 6'd0, 6'b001001, 6'd0, 8'h89, 3'b010};
        vecs[3] = '{2'd1, 3'b010, 6'd0, 6'b000101, 6'd0, 8'h85, 3'b010};
        vecs[4] = '{2'd2, 3'b100, 6'd0, 6'd0, 6'b001010, 8'h8A, 3'b100};
        vecs[5] = '{2'd2, 3'b100, 6'd0, 6'd0, 6'b001111, 8'h80, 3'b100};
        vecs[6] = '{2'd2, 3'b011, 6'd0, 6'd0, 6'b000001, 8'h80, 3'b100};
        vecs[7] = '{2'd3, 3'b000, 6'd0, 6'd0, 6'd0, 8'h80, 3'b000};
        vecs[8] = '{2'd0, 3'b001, 6'b000001, 6'd0, 6'd0, 8'h81, 3'b001};

        mode_sel = 2'd3; req = 3'b000; cmd_man = '0; cmd_semi = '0; cmd_auto = '0; tx_ready = 1'b1;
        #22;
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_tx_data", int'(tx_data), 8'h80);
        chk("rst_grant", int'(grant), 0);
        chk("rst_conflict", int'(conflict), 0);
        chk("rst_in_deadtime", int'(in_deadtime), 0);
        @(posedge sys_clk);
        #1 rst = 1'b1;
        got_q.delete();

        // Startup: STOP, dead-time, then manual frame and periodic refresh.
        step(2);
        mode_sel = 2'd0; req = 3'b001; cmd_man = 6'b000001;
        exp_q.push_back(8'h80); exp_q.push_back(8'h81);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (in_deadtime) n++;
        end
        chk("deadtime_len", n, 8);
        chk("grant_man", int'(grant), 3'b001);
        step(40);
        check_frames("startup", 8'h00);
        chk("refresh_period", acc_t[acc_t.size()-1] - acc_t[acc_t.size()-2], 16);

        // Opposing bits are cleared with a single conflict pulse each time.
        cmd_man = 6'b000011;
        exp_q.push_back(8'h80);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (conflict) n++;
        end
        chk("conflict_fb", n, 1);
        cmd_man = 6'b001100;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (conflict) n++;
        end
        chk("conflict_lr", n, 1);
        step(20);
        check_frames("conflict", 8'h81);

        // Held place request yields one pulse frame.
        cmd_man = 6'b010000;
        exp_q.push_back(8'h90); exp_q.push_back(8'h80);
        step(40);
        cmd_man = 6'b000000;
        step(20);
        n90 = 0;
        foreach (got_q[i]) if (got_q[i] == 8'h90) n90++;
        chk("place_once", n90, 1);
        check_frames("place", 8'h80);

        // Blocked transmitter: frozen byte goes first, newest command follows.
        cmd_man = 6'b000001;
        exp_q.push_back(8'h81);
        step(30);
        tx_ready = 1'b0;
        wait_valid(40);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3)  cmd_man = 6'b000101;
            if (i == 10) cmd_man = 6'b001001;
            step(1);
            if (!(tx_valid && tx_data == 8'h81)) bad++;
        end
        chk("blocked_hold", bad, 0);
        tx_ready = 1'b1;
        exp_q.push_back(8'h89);
        step(30);
        n85 = 0;
        foreach (got_q[i]) if (got_q[i] == 8'h85) n85++;
        chk("dropped_85", n85, 0);
        check_frames("blocked", 8'h80);

        // Steady-state vectors across owners and request masks.
        foreach (vecs[k]) begin
            mode_sel = vecs[k].mode; req = vecs[k].rq;
            cmd_man = vecs[k].man; cmd_semi = vecs[k].semi; cmd_auto = vecs[k].aut;
            exp_q.push_back(vecs[k].frame);
            step(45);
            chk($sformatf("vec%0d_frame", k), int'(last_frame), int'(exp_q.pop_front()));
            chk($sformatf("vec%0d_grant", k), int'(grant), int'(vecs[k].gnt));
            chk($sformatf("vec%0d_deadtime", k), int'(in_deadtime), 0);
        end
        got_q.delete();

        // Owner change restarted mid dead-time.
        req = 3'b111; cmd_semi = 6'b000100; cmd_auto = 6'b000010;
        step(2);
        mode_sel = 2'd1;
        exp_q.push_back(8'h80); exp_q.push_back(8'h82);
        n = 0;
        while (!in_deadtime && n < 5) begin
            step(1);
            n++;
        end
        chk("enter_deadtime", int'(in_deadtime), 1);
        step(4);
        mode_sel = 2'd2;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (grant != 3'b000) break;
            n++;
        end
        chk("restart_gap", n, 8);
        chk("grant_auto", int'(grant), 3'b100);
        step(30);
        check_frames("mode_change", 8'h81);

        // Asynchronous reset while a frame is pending and blocked.
        tx_ready = 1'b0;
        cmd_auto = 6'b001000;
        wait_valid(40);
        @(posedge sys_clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_tx_valid", int'(tx_valid), 0);
        chk("arst_tx_data", int'(tx_data), 8'h80);
        chk("arst_grant", int'(grant), 0);
        chk("arst_in_deadtime", int'(in_deadtime), 0);
        step(3);
        chk("arst_hold_valid", int'(tx_valid), 0);
        rst = 1'b1;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
